// File: rtl/mem_lsu_if.sv
// mem_lsu_if: CPU request/response handshake plus word-wide RAM port of the load/store unit.
interface mem_lsu_if #(
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-3:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport master (
        output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_re, ram_we, ram_wdata
    );

    modport slave (
        input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_re, ram_we, ram_wdata
    );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: byte/half/word load-store unit over a 1-cycle registered word RAM,
// with lane extraction, sign/zero extension and read-modify-write for sub-word stores.
module mem_lsu #(
    parameter int ADDR_W    = 16,
    parameter int RAM_WORDS = 4096
) (
    input logic      clk,
    input logic      rst,
    mem_lsu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t      state, state_n;
    logic        st, sgn;
    logic [1:0]  size, lane;
    logic        acc, err, full_store;
    logic [4:0]  sh;
    logic [31:0] lane_data, load_data, mask, merged;

    assign bus.req_ready = state == IDLE && !rst;
    assign bus.ram_re    = state == RD;
    assign bus.ram_we    = state == WR;
    assign acc           = bus.req_valid && bus.req_ready;
    assign err           = bus.req_size == 2'd3
                        || (bus.req_size == 2'd1 && bus.req_addr[0])
                        || (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'd0)
                        || 32'(bus.req_addr[ADDR_W-1:2]) >= 32'(RAM_WORDS);
    assign full_store    = bus.req_store && bus.req_size == 2'd2;

    // Halves are 2-byte aligned, so lane*8 already equals addr[1]*16 for them.
    assign sh        = {lane, 3'b000};
    assign lane_data = bus.ram_rdata >> sh;
    assign load_data = size == 2'd0 ? {{24{sgn & lane_data[7]}}, lane_data[7:0]}
                     : size == 2'd1 ? {{16{sgn & lane_data[15]}}, lane_data[15:0]}
                     : lane_data;
    assign mask      = (size == 2'd0 ? 32'h0000_00ff : 32'h0000_ffff) << sh;
    assign merged    = (bus.ram_rdata & ~mask) | ((bus.ram_wdata << sh) & mask);

    always_comb
        state_n = state == IDLE ? (acc && !err ? (full_store ? WR : RD) : IDLE)
                : state == RD ? CAP
                : state == CAP && st ? WR
                : IDLE;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    // ram_wdata doubles as the latched store data until the RMW merge replaces it.
    always_ff @(posedge clk)
        if (rst) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.ram_addr  <= '0;
            bus.ram_wdata <= '0;
        end else begin
            bus.rsp_valid <= (acc && err) || (state == CAP && !st) || state == WR;
            if (acc) begin
                st            <= bus.req_store;
                size          <= bus.req_size;
                sgn           <= bus.req_signed;
                lane          <= bus.req_addr[1:0];
                bus.ram_addr  <= bus.req_addr[ADDR_W-1:2];
                bus.ram_wdata <= bus.req_wdata;
            end
            if (acc && err) begin
                bus.rsp_err   <= 1'b1;
                bus.rsp_rdata <= '0;
            end
            if (state == CAP && st)
                bus.ram_wdata <= merged;
            if (state == CAP && !st) begin
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= load_data;
            end
            if (state == WR) begin
                bus.rsp_err   <= 1'b0;
                bus.rsp_rdata <= '0;
            end
        end
endmodule
